// File: rtl/filter_read_addr_gen.sv
// Read-side address generator for the filter scratchpad: walks each filter,
// replays it reuse_count times, then pulses next_filter to step the start tracker.
module filter_read_addr_gen #(
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_FILTER_SIZE = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MAX_FILTER_SIZE-1:0] filter_size,
  input  logic                       interleaved_mode,
  input  logic [COUNT_WIDTH-1:0]     num_filters,
  input  logic [COUNT_WIDTH-1:0]     reuse_count,
  input  logic [ADDR_WIDTH-1:0]      filter_start_addr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_last,
  output logic                       next_filter,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = MAX_FILTER_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ADVANCE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]       len_q, len_d;
  logic [COUNT_WIDTH-1:0] reuse_q, reuse_d;
  logic [COUNT_WIDTH-1:0] nfilt_q, nfilt_d;
  logic [LEN_W-1:0]       elem_q, elem_d;
  logic [COUNT_WIDTH-1:0] pass_q, pass_d;
  logic [COUNT_WIDTH-1:0] filt_q, filt_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;

  logic                   rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                   rd_last_q, rd_last_d;
  logic                   next_filter_q, next_filter_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LEN_W-1:0]       start_len;
  logic                   handshake;
  logic                   elem_end;
  logic                   pass_end;
  logic                   filt_end;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    reuse_d   = reuse_q;
    nfilt_d   = nfilt_q;
    elem_d    = elem_q;
    pass_d    = pass_q;
    filt_d    = filt_q;
    base_d    = base_q;

    start_len = interleaved_mode ? {filter_size, 1'b0} : {1'b0, filter_size};
    handshake = rd_valid_q & rd_ready;
    elem_end  = (elem_q == len_q - LEN_W'(1));
    pass_end  = (pass_q == reuse_q - COUNT_WIDTH'(1));
    filt_end  = (filt_q == nfilt_q - COUNT_WIDTH'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = start_len;
          reuse_d = (reuse_count == '0) ? COUNT_WIDTH'(1) : reuse_count;
          nfilt_d = num_filters;
          elem_d  = '0;
          pass_d  = '0;
          filt_d  = '0;
          if (start_len == '0 || num_filters == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            base_d  = filter_start_addr;
          end
        end
      end
      S_READ: begin
        if (handshake) begin
          if (!elem_end) begin
            elem_d = elem_q + LEN_W'(1);
          end else if (!pass_end) begin
            // Next pass starts straight away so the stream has no bubble.
            elem_d = '0;
            pass_d = pass_q + COUNT_WIDTH'(1);
          end else if (!filt_end) begin
            state_d = S_ADVANCE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADVANCE: begin
        filt_d  = filt_q + COUNT_WIDTH'(1);
        pass_d  = '0;
        elem_d  = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // The tracker has stepped by now, so its new base is safe to latch.
        base_d  = filter_start_addr;
        state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_valid_d    = (state_d == S_READ);
    rd_addr_d     = rd_valid_d ? (base_d + ADDR_WIDTH'(elem_d)) : '0;
    rd_last_d     = rd_valid_d && (elem_d == len_d - LEN_W'(1));
    next_filter_d = (state_d == S_ADVANCE);
    busy_d        = (state_d == S_READ) || (state_d == S_ADVANCE) || (state_d == S_SETTLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      reuse_q       <= '0;
      nfilt_q       <= '0;
      elem_q        <= '0;
      pass_q        <= '0;
      filt_q        <= '0;
      base_q        <= '0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_last_q     <= 1'b0;
      next_filter_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      reuse_q       <= reuse_d;
      nfilt_q       <= nfilt_d;
      elem_q        <= elem_d;
      pass_q        <= pass_d;
      filt_q        <= filt_d;
      base_q        <= base_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_last_q     <= rd_last_d;
      next_filter_q <= next_filter_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_last     = rd_last_q;
  assign next_filter = next_filter_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
